sr_reg_bank: RTL and testbench
==============================

SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent SR channels, legal range 1..32.
REQ-002 Parameter MODE, default MODE_HOLD, conflict resolution when set and reset are both active: MODE_SET (set wins), MODE_RST (reset wins), MODE_HOLD (keep state), MODE_TOGGLE (invert state).
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 0..3 (0 = inputs used directly).
REQ-004 Parameter CNT_W, default 8, width of the conflict event counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_n  input  WIDTH  per-channel set request, active-low (NAND-latch convention).
REQ-008 r_n  input  WIDTH  per-channel reset request, active-low.
REQ-009 clr_err  input  1  synchronous clear of conflict_sticky and conflict_cnt.
REQ-010 q  output  WIDTH  per-channel stored state.
REQ-011 q_n  output  WIDTH  bitwise complement of q, always, including during reset.
REQ-012 conflict  output  WIDTH  per-channel one-cycle pulse marking a sampled s_n=0, r_n=0 condition.
REQ-013 conflict_sticky  output  1  set by any conflict, held until clr_err or rst.
REQ-014 conflict_cnt  output  CNT_W  saturating count of cycles in which at least one channel was in conflict.

Function
REQ-015 s_n and r_n SHALL pass through SYNC_STAGES flops per bit; the synchronised values are s_i, r_i.
REQ-016 Per channel, the next q SHALL be: s_i=1,r_i=1 -> hold; s_i=0,r_i=1 -> 1; s_i=1,r_i=0 -> 0; s_i=0,r_i=0 -> per MODE.
REQ-017 Latency from an input change at s_n/r_n to q SHALL be SYNC_STAGES+1 rising edges.
REQ-018 conflict[i] SHALL be registered, asserted in the same cycle q reflects the conflicting sample, for one cycle per conflicting sample.
REQ-019 A conflict held for N consecutive samples SHALL produce N conflict pulses, N counter increments and, in MODE_TOGGLE, N inversions.
REQ-020 conflict_cnt SHALL increment by exactly 1 per cycle with any channel in conflict, regardless of how many channels, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-021 clr_err together with a new conflict in the same cycle: clear wins for the cycle of clr_err; conflict_sticky=0 and conflict_cnt=0 next cycle. The conflict pulse itself is still produced, and the next conflict sets/counts normally.
REQ-022 Channels SHALL be fully independent; a conflict on one channel SHALL NOT alter any other channel's q.
REQ-023 q SHALL never glitch between edges; q_n SHALL be derived combinationally as ~q.

Reset
REQ-024 rst=1 SHALL immediately and asynchronously force q=0, q_n=all ones, conflict=0, conflict_sticky=0, conflict_cnt=0, and all synchroniser flops to 1 (inactive).
REQ-025 After rst deasserts, the first state change SHALL occur no earlier than SYNC_STAGES+1 edges later; reset asserted mid-conflict SHALL discard the conflict with no count.

Structure
REQ-026 Package sr_pkg SHALL hold the MODE constants (MODE_SET=0, MODE_RST=1, MODE_HOLD=2, MODE_TOGGLE=3) and the default parameter values.
REQ-027 One sub-module sr_sync (1-bit synchroniser, SYNC_STAGES parameter, reset value 1) SHALL be instantiated 2*WIDTH times; the SR update logic stays in sr_reg_bank.

Verification
REQ-028 WIDTH=8, SYNC_STAGES=2: rst pulse then s_n=8'hFE at edge 0 -> q=8'h01 after edge 3, q_n=8'hFE.
REQ-029 From q=8'h01, r_n=8'hFE for one sample -> q=8'h00 three edges later; conflict stays 0.
REQ-030 MODE_TOGGLE, q[0]=0, s_n[0]=r_n[0]=0 for 3 samples -> q[0] sequence 1,0,1, conflict[0] high 3 cycles, conflict_cnt=3, conflict_sticky=1.
REQ-031 MODE_SET vs MODE_RST vs MODE_HOLD with q[3]=0 and one conflicting sample on channel 3 -> q[3]=1, 0, 0 respectively; all other bits unchanged.
REQ-032 CNT_W=2, conflict held 6 samples -> conflict_cnt 1,2,3,3,3,3; then clr_err coincident with a conflict -> conflict_cnt=0, conflict_sticky=0 next cycle.
REQ-033 rst asserted between edges while q=8'hA5 -> q=8'h00 immediately without waiting for clk; inputs active at deassertion take effect SYNC_STAGES+1 edges later.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants for the SR register bank: conflict-resolution modes,
// default parameter values and the per-channel conflict resolver.
package sr_pkg;

  localparam int MODE_SET    = 0;
  localparam int MODE_RST    = 1;
  localparam int MODE_HOLD   = 2;
  localparam int MODE_TOGGLE = 3;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_MODE        = MODE_HOLD;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_CNT_W       = 8;

  // Next state of one channel when set and reset are requested together.
  function automatic logic resolve_conflict(input int mode, input logic cur);
    case (mode)
      MODE_SET:    return 1'b1;
      MODE_RST:    return 1'b0;
      MODE_TOGGLE: return ~cur;
      default:     return cur;
    endcase
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Single-bit input synchroniser. Flops reset to 1 so an active-low request
// reads as inactive until a real sample has travelled through the chain.
module sr_sync
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] stage_reg;

      // Shift the raw input through the flop chain, stage 0 first.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg <= '1;
        end else begin
          stage_reg[0] <= d;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign q = stage_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of independent clocked SR latches with active-low set/reset inputs,
// configurable conflict resolution, per-channel conflict pulses, and a
// sticky flag plus saturating counter of conflict cycles.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int MODE        = DEFAULT_MODE,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_n,
  input  logic [WIDTH-1:0] r_n,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] s_i;
  logic [WIDTH-1:0] r_i;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_reg;
  logic [WIDTH-1:0] conflict_next;
  logic             sticky_reg;
  logic             sticky_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             any_conflict;

  // Two synchronisers per channel: one for set, one for reset.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sync
      sr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk (clk),
        .rst (rst),
        .d   (s_n[gi]),
        .q   (s_i[gi])
      );
      sr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
        .clk (clk),
        .rst (rst),
        .d   (r_n[gi]),
        .q   (r_i[gi])
      );
    end
  endgenerate

  // Per-channel SR truth table on the synchronised active-low requests.
  always_comb begin
    q_next        = q_reg;
    conflict_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s_i[i], r_i[i]})
        2'b11: q_next[i] = q_reg[i];
        2'b01: q_next[i] = 1'b1;
        2'b10: q_next[i] = 1'b0;
        default: begin
          q_next[i]        = resolve_conflict(MODE, q_reg[i]);
          conflict_next[i] = 1'b1;
        end
      endcase
    end
  end

  assign any_conflict = |conflict_next;

  // Error bookkeeping: a clear in the same cycle as a conflict wins, and the
  // counter counts cycles (not channels) and sticks at its maximum.
  always_comb begin
    sticky_next = sticky_reg;
    cnt_next    = cnt_reg;
    if (clr_err) begin
      sticky_next = 1'b0;
      cnt_next    = '0;
    end else if (any_conflict) begin
      sticky_next = 1'b1;
      if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Register state, conflict pulses and error bookkeeping together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg        <= '0;
      conflict_reg <= '0;
      sticky_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= conflict_next;
      sticky_reg   <= sticky_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign q               = q_reg;
  assign q_n             = ~q_reg;
  assign conflict        = conflict_reg;
  assign conflict_sticky = sticky_reg;
  assign conflict_cnt    = cnt_reg;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: five instances share one stimulus stream and differ in
// conflict mode (set/reset/hold/toggle) and counter width (8 and 2 bits).
module tb_sr_reg_bank;
  import sr_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] s_n;
  logic [7:0] r_n;
  logic       clr_err;

  logic [7:0] h_q, h_qn, h_cf, h_cnt;
  logic       h_st;
  logic [7:0] s_q, s_qn, s_cf, s_cnt;
  logic       s_st;
  logic [7:0] r_q, r_qn, r_cf, r_cnt;
  logic       r_st;
  logic [7:0] t_q, t_qn, t_cf, t_cnt;
  logic       t_st;
  logic [7:0] c_q, c_qn, c_cf;
  logic [1:0] c_cnt;
  logic       c_st;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sr_reg_bank #(.WIDTH(8), .MODE(MODE_HOLD), .SYNC_STAGES(2), .CNT_W(8)) u_hold (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(h_q), .q_n(h_qn), .conflict(h_cf), .conflict_sticky(h_st), .conflict_cnt(h_cnt));
  sr_reg_bank #(.WIDTH(8), .MODE(MODE_SET), .SYNC_STAGES(2), .CNT_W(8)) u_set (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(s_q), .q_n(s_qn), .conflict(s_cf), .conflict_sticky(s_st), .conflict_cnt(s_cnt));
  sr_reg_bank #(.WIDTH(8), .MODE(MODE_RST), .SYNC_STAGES(2), .CNT_W(8)) u_rst (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(r_q), .q_n(r_qn), .conflict(r_cf), .conflict_sticky(r_st), .conflict_cnt(r_cnt));
  sr_reg_bank #(.WIDTH(8), .MODE(MODE_TOGGLE), .SYNC_STAGES(2), .CNT_W(8)) u_tog (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(t_q), .q_n(t_qn), .conflict(t_cf), .conflict_sticky(t_st), .conflict_cnt(t_cnt));
  sr_reg_bank #(.WIDTH(8), .MODE(MODE_HOLD), .SYNC_STAGES(2), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(c_q), .q_n(c_qn), .conflict(c_cf), .conflict_sticky(c_st), .conflict_cnt(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sat_exp [6];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; s_n = 8'hFF; r_n = 8'hFF; clr_err = 1'b0;

    // Reset state, before any clock edge
    #2;
    check("rst_q", h_q, 8'h00);
    check("rst_qn", h_qn, 8'hFF);
    check("rst_conflict", h_cf, 8'h00);
    check("rst_sticky", {7'd0, h_st}, 8'h00);
    check("rst_cnt", h_cnt, 8'h00);
    check("rst_tog_q", t_q, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Set channel 0: visible after the third edge
    s_n = 8'hFE;
    tick(); tick();
    check("set_latency_q", h_q, 8'h00);
    tick();
    check("set_q", h_q, 8'h01);
    check("set_qn", h_qn, 8'hFE);
    s_n = 8'hFF;

    // Reset channel 0 for one sample
    r_n = 8'hFE;
    tick();
    r_n = 8'hFF;
    tick();
    check("clr_latency_q", h_q, 8'h01);
    tick();
    check("clr_q", h_q, 8'h00);
    check("clr_conflict", h_cf, 8'h00);
    check("clr_sticky", {7'd0, h_st}, 8'h00);

    // Mode comparison: q=81, then one conflict sample on channel 3
    s_n = 8'h7E;
    tick();
    s_n = 8'hFF;
    tick(); tick();
    check("pre_mode_q", t_q, 8'h81);
    s_n = 8'hF7; r_n = 8'hF7;
    tick();
    s_n = 8'hFF; r_n = 8'hFF;
    tick(); tick();
    check("mode_set_q", s_q, 8'h89);
    check("mode_rst_q", r_q, 8'h81);
    check("mode_hold_q", h_q, 8'h81);
    check("mode_tog_q", t_q, 8'h89);
    check("mode_conflict", h_cf, 8'h08);
    check("mode_cnt", h_cnt, 8'h01);
    tick();
    check("mode_conflict_end", h_cf, 8'h00);
    check("mode_sticky", {7'd0, h_st}, 8'h01);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_sticky", {7'd0, h_st}, 8'h00);
    check("clr_err_cnt", h_cnt, 8'h00);

    // Toggle mode: clear bit 0, then three conflict samples on channel 0
    r_n = 8'hFE;
    tick();
    r_n = 8'hFF;
    tick(); tick();
    check("pre_tog_q", t_q, 8'h88);
    check("pre_tog_rst_q", r_q, 8'h80);
    s_n = 8'hFE; r_n = 8'hFE;
    tick(); tick(); tick();
    s_n = 8'hFF; r_n = 8'hFF;
    check("tog_q_1", t_q, 8'h89);
    check("tog_conflict_1", t_cf, 8'h01);
    tick();
    check("tog_q_2", t_q, 8'h88);
    check("tog_conflict_2", t_cf, 8'h01);
    tick();
    check("tog_q_3", t_q, 8'h89);
    check("tog_conflict_3", t_cf, 8'h01);
    check("tog_cnt_3", t_cnt, 8'h03);
    tick();
    check("tog_conflict_end", t_cf, 8'h00);
    check("tog_cnt", t_cnt, 8'h03);
    check("tog_sticky", {7'd0, t_st}, 8'h01);
    check("tog_set_q", s_q, 8'h89);
    check("tog_rst_q", r_q, 8'h80);
    check("tog_hold_q", h_q, 8'h80);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Saturation with a 2-bit counter: eight conflict samples
    s_n = 8'hFE; r_n = 8'hFE;
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("sat_cnt_%0d", k), {6'd0, c_cnt}, {6'd0, sat_exp[k]});
    end
    check("sat_wide_cnt", h_cnt, 8'h06);
    clr_err = 1'b1;
    s_n = 8'hFF; r_n = 8'hFF;
    tick();
    clr_err = 1'b0;
    check("clrwin_cnt", {6'd0, c_cnt}, 8'h00);
    check("clrwin_sticky", {7'd0, c_st}, 8'h00);
    check("clrwin_conflict", c_cf, 8'h01);
    tick();
    check("after_clr_cnt", {6'd0, c_cnt}, 8'h01);
    check("after_clr_sticky", {7'd0, c_st}, 8'h01);
    tick();
    check("after_clr_conflict_end", c_cf, 8'h00);

    // Asynchronous reset mid-conflict from q=A5
    s_n = 8'h5A; r_n = 8'hA5;
    tick();
    s_n = 8'hFF; r_n = 8'hFF;
    tick(); tick();
    check("pre_async_q", h_q, 8'hA5);
    check("pre_async_tog_q", t_q, 8'hA5);
    s_n = 8'hFE; r_n = 8'hFE;
    tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_q", h_q, 8'h00);
    check("async_qn", h_qn, 8'hFF);
    check("async_tog_q", t_q, 8'h00);
    check("async_cnt", h_cnt, 8'h00);
    check("async_sticky", {7'd0, h_st}, 8'h00);
    s_n = 8'hF0; r_n = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_latency_q", h_q, 8'h00);
    tick();
    check("post_rst_q", h_q, 8'h0F);
    check("post_rst_cnt", h_cnt, 8'h00);
    check("post_rst_sticky", {7'd0, h_st}, 8'h00);
    check("post_rst_conflict", h_cf, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
